// File: rtl/controller_stage2.sv
// Second-stage sequencer: for every output sample it reads one word from each of
// four FIFOs into an accumulator, presents the result, and repeats for N_SAMPLES.
module controller_stage2 #(
    parameter int N_SAMPLES = 88
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       empty_FIFO1,
    input  logic       empty_FIFO2,
    input  logic       empty_FIFO3,
    input  logic       empty_FIFO4,
    input  logic       out_ready,
    output logic       read_FIFO1,
    output logic       read_FIFO2,
    output logic       read_FIFO3,
    output logic       read_FIFO4,
    output logic [1:0] sel_mux,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       out_valid,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        READ,
        DRAIN,
        OUT,
        DONE
    } state_t;

    localparam logic [6:0] LAST_SAMPLE = 7'(N_SAMPLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] phase;
    logic [6:0] sample_cnt;
    logic [3:0] empty_vec;
    logic [3:0] read_vec;
    logic       rd_go;
    logic       last_sample;
    logic       handshake;

    assign empty_vec   = {empty_FIFO4, empty_FIFO3, empty_FIFO2, empty_FIFO1};
    // The strobe is gated by the live empty flag so it drops in the same cycle empty rises.
    assign rd_go       = (state == READ) && !empty_vec[phase];
    assign last_sample = (sample_cnt == LAST_SAMPLE);
    assign handshake   = (state == OUT) && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 2'd0;
            sample_cnt <= 7'd0;
            sel_mux    <= 2'd0;
            acc_en     <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc_en <= rd_go;
            if (state == CLEAR) begin
                phase <= 2'd0;
            end
            if (rd_go) begin
                sel_mux <= phase;
                phase   <= phase + 2'd1;
            end
            if (state == IDLE && start) begin
                sample_cnt <= 7'd0;
            end
            // The counter saturates at the final sample instead of wrapping; sel_mux
            // returns to 0 so DONE and IDLE present an all-zero output set.
            if (handshake) begin
                if (last_sample) begin
                    sel_mux <= 2'd0;
                end else begin
                    sample_cnt <= sample_cnt + 7'd1;
                end
            end
        end
    end

    // NOTE: each combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = READ;
            READ:    if (rd_go && phase == 2'd3) state_nxt = DRAIN;
            DRAIN:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = last_sample ? DONE : CLEAR;
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        read_vec  = 4'b0000;
        acc_clr   = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            CLEAR:   acc_clr = 1'b1;
            READ:    if (rd_go) read_vec = 4'b0001 << phase;
            OUT:     out_valid = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign read_FIFO1 = read_vec[0];
    assign read_FIFO2 = read_vec[1];
    assign read_FIFO3 = read_vec[2];
    assign read_FIFO4 = read_vec[3];

endmodule
